fp_multiplier_pipe: RTL

FP_MULTIPLIER_PIPE -- requirements
Module: fp_multiplier_pipe

---
 rtl/fp_multiplier_pipe.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_multiplier_pipe.sv
// fp_multiplier_pipe
//   Three-stage pipelined floating-point multiplier for {sign, exp, frac}
//   operands. Subnormal inputs are treated as signed zero, and there are no
//   subnormal outputs.
//     S1: unpack the operands, detect special cases, XOR the signs and form
//         the exponent sum ex+ey-bias.
//     S2: multiply the significands.
//     S3: normalize, round, check the range and pack the result.
//
//   Handshake: in_ready and out_ready follow valid/ready rules. A pair
//   transfers on a rising edge where in_valid && in_ready. A result
//   transfers where out_valid && out_ready. All stages advance together
//   whenever the output register is empty or being consumed. Bubbles are
//   kept in place and are not collapsed. The output holds steady while it
//   is stalled.
//
//   Configuration macro FP_MUL_ROUND_NEAREST_EN:
//     defined   -> round to nearest, ties to even (guard + sticky)
//     undefined -> truncate toward zero
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   operand handshake, x and y operands
//     out_valid/out_ready result handshake
//     z                   product
//     ovf / unf / nan     overflow to inf / nonzero result flushed to zero / NaN
module fp_multiplier_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x,
  input  logic [EXP_W+MAN_W:0]   y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic                   ovf,
  output logic                   unf,
  output logic                   nan
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;       // signed exponent width, absorbs range overflow
  localparam int PW = 2 * MAN_W + 2;   // full product width
  localparam logic signed [EW-1:0] BIAS    = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [1:0] {
    K_NORM = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_t;

  // Stage registers
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;
  logic [MAN_W:0]       s1_man_x_q, s1_man_x_d;
  logic [MAN_W:0]       s1_man_y_q, s1_man_y_d;
  kind_t                s1_kind_q, s1_kind_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q, s2_sign_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [PW-1:0]        s2_prod_q, s2_prod_d;
  kind_t                s2_kind_q, s2_kind_d;

  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         z_q, z_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 nan_q, nan_d;

  logic adv;

  // Stage 1 decode
  logic [EXP_W-1:0]     x_exp, y_exp;
  logic                 x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic signed [EW-1:0] exp_sum;
  kind_t                in_kind;

  // Stage 3 datapath
  logic                 norm_shift;
  logic [MAN_W:0]       norm_man;
  logic [MAN_W+1:0]     man_rnd;
  logic                 rnd_carry;
  logic signed [EW-1:0] exp_fin;
  logic [MAN_W-1:0]     frac_fin;
  logic [W-1:0]         res_z;
  logic                 res_ovf, res_unf, res_nan;
  logic                 unused_bits;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign x_exp  = x[W-2:MAN_W];
  assign y_exp  = y[W-2:MAN_W];
  assign x_zero = (x_exp == '0);
  assign y_zero = (y_exp == '0);
  assign x_inf  = (x_exp == '1) && (x[MAN_W-1:0] == '0);
  assign y_inf  = (y_exp == '1) && (y[MAN_W-1:0] == '0);
  assign x_nan  = (x_exp == '1) && (x[MAN_W-1:0] != '0);
  assign y_nan  = (y_exp == '1) && (y[MAN_W-1:0] != '0);
  assign exp_sum = $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - BIAS;

  // Special-case priority: NaN (including inf*0) first, then inf, then zero.
  always_comb begin
    in_kind = K_NORM;
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      in_kind = K_NAN;
    end else if (x_inf || y_inf) begin
      in_kind = K_INF;
    end else if (x_zero || y_zero) begin
      in_kind = K_ZERO;
    end
  end

  // The product of two [1,2) significands lies in [1,4), so the leading
  // one sits at bit PW-1 (shift right by one) or at bit PW-2.
  assign norm_shift = s2_prod_q[PW-1];
  assign norm_man   = norm_shift ? s2_prod_q[PW-1:MAN_W+1] : s2_prod_q[PW-2:MAN_W];

`ifdef FP_MUL_ROUND_NEAREST_EN
  logic guard_bit, sticky_bit, round_up;
  assign guard_bit  = norm_shift ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
  assign sticky_bit = norm_shift ? |s2_prod_q[MAN_W-1:0] : |s2_prod_q[MAN_W-2:0];
  assign round_up   = guard_bit && (sticky_bit || norm_man[0]);
  assign man_rnd    = {1'b0, norm_man} + {{(MAN_W+1){1'b0}}, round_up};
  assign unused_bits = man_rnd[MAN_W];
`else
  assign man_rnd     = {1'b0, norm_man};
  assign unused_bits = ^{s2_prod_q[MAN_W-1:0], man_rnd[MAN_W]};
`endif

  // A rounding carry turns 1.11..1 into 10.00..0: bump the exponent and
  // clear the fraction.
  assign rnd_carry = man_rnd[MAN_W+1];
  assign exp_fin   = s2_exp_q
                   + $signed({{(EW-1){1'b0}}, norm_shift})
                   + $signed({{(EW-1){1'b0}}, rnd_carry});
  assign frac_fin  = rnd_carry ? '0 : man_rnd[MAN_W-1:0];

  always_comb begin
    res_z   = {s2_sign_q, exp_fin[EXP_W-1:0], frac_fin};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_nan = 1'b0;
    case (s2_kind_q)
      K_NAN: begin
        res_z   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        res_nan = 1'b1;
      end
      K_INF:  res_z = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: res_z = {s2_sign_q, {(W-1){1'b0}}};
      default: begin
        if (exp_fin >= EXP_MAX) begin
          res_z   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          res_ovf = 1'b1;
        end else if (exp_fin < EXP_ONE) begin
          res_z   = {s2_sign_q, {(W-1){1'b0}}};
          res_unf = 1'b1;
        end
      end
    endcase
  end

  // Next-state logic: everything holds unless the pipe advances.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_man_x_d  = s1_man_x_q;
    s1_man_y_d  = s1_man_y_q;
    s1_kind_d   = s1_kind_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_exp_d    = s2_exp_q;
    s2_prod_d   = s2_prod_q;
    s2_kind_d   = s2_kind_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    nan_d       = nan_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d  = x[W-1] ^ y[W-1];
        s1_exp_d   = exp_sum;
        s1_man_x_d = {1'b1, x[MAN_W-1:0]};
        s1_man_y_d = {1'b1, y[MAN_W-1:0]};
        s1_kind_d  = in_kind;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_exp_d  = s1_exp_q;
        s2_prod_d = PW'(s1_man_x_q) * PW'(s1_man_y_q);
        s2_kind_d = s1_kind_q;
      end
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        z_d   = res_z;
        ovf_d = res_ovf;
        unf_d = res_unf;
        nan_d = res_nan;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_man_x_q  <= '0;
      s1_man_y_q  <= '0;
      s1_kind_q   <= K_NORM;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      s2_kind_q   <= K_NORM;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      nan_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_man_x_q  <= s1_man_x_d;
      s1_man_y_q  <= s1_man_y_d;
      s1_kind_q   <= s1_kind_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s2_prod_d;
      s2_kind_q   <= s2_kind_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      nan_q       <= nan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign nan       = nan_q;

endmodule
